// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, operator encoding and controller states for the calculator
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [2:0] {
      S_OP1, S_OP2, S_WAIT, S_RESULT, S_CLRPEND, S_ERR
   } state_t;

   typedef enum logic [1:0] {
      K_DIGIT, K_OPER, K_EQ, K_CLR
   } key_class_t;

   function automatic key_class_t key_decode(input logic [3:0] code);
      if (code <= 4'd9)        return K_DIGIT;
      else if (code == KEY_EQ)  return K_EQ;
      else if (code == KEY_CLR) return K_CLR;
      else                      return K_OPER;
   endfunction

   function automatic logic [1:0] key_to_op(input logic [3:0] code);
      logic [3:0] w_d;
      w_d = code - KEY_ADD;
      return w_d[1:0];
   endfunction

endpackage

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad-to-operand sequencer; all outputs registered, latency 1.
// Define CALC_CHAIN_EN to let an operator in the result state continue from the result.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int MAX_DIGITS   = 4,
   parameter int CALC_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic       calc_done,
   output logic [3:0] digits,
   output logic       newNumber,
   output logic       opnumber,
   output logic [1:0] digitnumber,
   output logic [1:0] op_clear,
   output logic [1:0] op_code,
   output logic       calc_start,
   output logic       load_result,
   output logic       result_valid,
   output logic       err,
   output logic       key_rejected
);

   localparam logic [2:0] MAXD  = 3'(MAX_DIGITS);
   localparam logic [7:0] TLAST = 8'(CALC_TIMEOUT - 1);

   state_t     r_state, w_state_nxt;
   logic [2:0] r_cnt, w_cnt;
   logic [7:0] r_timer, w_timer;
   logic [3:0] r_pend, w_pend;
   logic       r_key_ready;
   logic [3:0] r_digits, w_digits;
   logic       r_new, w_new;
   logic       r_opn, w_opn;
   logic [1:0] r_dpos, w_dpos;
   logic [1:0] r_clr, w_clr;
   logic [1:0] r_op, w_op;
   logic       r_start, w_start;
   logic       r_load, w_load;
   logic       r_rv, w_rv;
   logic       r_err, w_err;
   logic       r_rej, w_rej;

   logic       w_acc;
   key_class_t w_kc;

   assign w_acc = key_valid & r_key_ready;
   assign w_kc  = key_decode(key_code);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_OP1;
         r_cnt       <= '0;
         r_timer     <= '0;
         r_pend      <= '0;
         r_key_ready <= 1'b1;
         r_digits    <= '0;
         r_new       <= 1'b0;
         r_opn       <= 1'b0;
         r_dpos      <= '0;
         r_clr       <= '0;
         r_op        <= '0;
         r_start     <= 1'b0;
         r_load      <= 1'b0;
         r_rv        <= 1'b0;
         r_err       <= 1'b0;
         r_rej       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt;
         r_timer     <= w_timer;
         r_pend      <= w_pend;
         r_key_ready <= (w_state_nxt != S_WAIT) && (w_state_nxt != S_CLRPEND);
         r_digits    <= w_digits;
         r_new       <= w_new;
         r_opn       <= w_opn;
         r_dpos      <= w_dpos;
         r_clr       <= w_clr;
         r_op        <= w_op;
         r_start     <= w_start;
         r_load      <= w_load;
         r_rv        <= w_rv;
         r_err       <= w_err;
         r_rej       <= w_rej;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_OP1: begin
            if (w_acc && w_kc == K_CLR) w_state_nxt = S_OP1;
            else if (w_acc && w_kc == K_OPER && r_cnt != 3'd0) w_state_nxt = S_OP2;
         end
         S_OP2: begin
            if (w_acc && w_kc == K_CLR) w_state_nxt = S_OP1;
            else if (w_acc && w_kc == K_EQ && r_cnt != 3'd0) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // completion on the final timer cycle still counts as success
            if (calc_done) w_state_nxt = S_RESULT;
            else if (r_timer == TLAST) w_state_nxt = S_ERR;
         end
         S_RESULT: begin
            if (w_acc && w_kc == K_CLR) w_state_nxt = S_OP1;
            else if (w_acc && w_kc == K_DIGIT) w_state_nxt = S_CLRPEND;
`ifdef CALC_CHAIN_EN
            else if (w_acc && w_kc == K_OPER) w_state_nxt = S_OP2;
`endif
         end
         S_CLRPEND: w_state_nxt = S_OP1;
         S_ERR:     if (w_acc && w_kc == K_CLR) w_state_nxt = S_OP1;
         default:   w_state_nxt = S_OP1;
      endcase
   end

   always_comb begin
      w_cnt    = r_cnt;
      w_timer  = r_timer;
      w_pend   = r_pend;
      w_digits = r_digits;
      w_opn    = r_opn;
      w_dpos   = r_dpos;
      w_op     = r_op;
      w_rv     = r_rv;
      w_err    = r_err;
      w_new    = 1'b0;
      w_clr    = 2'b00;
      w_start  = 1'b0;
      w_load   = 1'b0;
      w_rej    = 1'b0;
      if (w_acc && w_kc == K_CLR) begin
         w_clr = 2'b11;
         w_cnt = '0;
         w_rv  = 1'b0;
         w_err = 1'b0;
      end else begin
         case (r_state)
            S_OP1, S_OP2: if (w_acc) begin
               if (w_kc == K_DIGIT) begin
                  if (r_cnt < MAXD) begin
                     w_new    = 1'b1;
                     w_digits = key_code;
                     w_opn    = (r_state == S_OP2);
                     w_dpos   = r_cnt[1:0];
                     w_cnt    = r_cnt + 3'd1;
                  end else w_rej = 1'b1;
               end else if (w_kc == K_OPER && r_state == S_OP1 && r_cnt != 3'd0) begin
                  w_op  = key_to_op(key_code);
                  w_cnt = '0;
               end else if (w_kc == K_EQ && r_state == S_OP2 && r_cnt != 3'd0) begin
                  w_start = 1'b1;
                  w_timer = '0;
               end else w_rej = 1'b1;
            end
            S_WAIT: begin
               if (calc_done) w_rv = 1'b1;
               else if (r_timer == TLAST) w_err = 1'b1;
               else w_timer = r_timer + 8'd1;
            end
            S_RESULT: if (w_acc) begin
               if (w_kc == K_DIGIT) begin
                  w_clr  = 2'b11;
                  w_rv   = 1'b0;
                  w_pend = key_code;
               end
`ifdef CALC_CHAIN_EN
               else if (w_kc == K_OPER) begin
                  w_load = 1'b1;
                  w_clr  = 2'b10;
                  w_op   = key_to_op(key_code);
                  w_rv   = 1'b0;
                  w_cnt  = '0;
               end
`endif
               else w_rej = 1'b1;
            end
            S_CLRPEND: begin
               w_new    = 1'b1;
               w_digits = r_pend;
               w_opn    = 1'b0;
               w_dpos   = 2'd0;
               w_cnt    = 3'd1;
            end
            S_ERR: if (w_acc) w_rej = 1'b1;
            default: ;
         endcase
      end
   end

   assign key_ready    = r_key_ready;
   assign digits       = r_digits;
   assign newNumber    = r_new;
   assign opnumber     = r_opn;
   assign digitnumber  = r_dpos;
   assign op_clear     = r_clr;
   assign op_code      = r_op;
   assign calc_start   = r_start;
   assign load_result  = r_load;
   assign result_valid = r_rv;
   assign err          = r_err;
   assign key_rejected = r_rej;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - table-driven key sequences with a digit-write scoreboard
module tb_calc_entry_ctrl;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       calc_done = 1'b0;
   logic       key_ready, newNumber, opnumber, calc_start, load_result;
   logic       result_valid, err, key_rejected;
   logic [3:0] digits;
   logic [1:0] digitnumber, op_clear, op_code;

   calc_entry_ctrl dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .calc_done(calc_done), .digits(digits),
      .newNumber(newNumber), .opnumber(opnumber), .digitnumber(digitnumber),
      .op_clear(op_clear), .op_code(op_code), .calc_start(calc_start),
      .load_result(load_result), .result_valid(result_valid), .err(err),
      .key_rejected(key_rejected)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] key;
      bit         rej;
      bit         nw;
      logic [3:0] dig;
      bit         opn;
      logic [1:0] pos;
      logic [1:0] clr;
   } vec_t;

   typedef struct {
      logic [3:0] d;
      bit         o;
      logic [1:0] p;
   } nn_t;

   vec_t tbl[$];
   nn_t  exp_q[$];
   nn_t  mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_start = 0;
   int   wait_cnt;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t dg(input logic [3:0] d, input bit o, input logic [1:0] p);
      dg = '{key: d, rej: 1'b0, nw: 1'b1, dig: d, opn: o, pos: p, clr: 2'b00};
   endfunction

   function automatic vec_t ky(input logic [3:0] k, input bit r, input logic [1:0] c);
      ky = '{key: k, rej: r, nw: 1'b0, dig: 4'd0, opn: 1'b0, pos: 2'd0, clr: c};
   endfunction

   task automatic press_vec(input vec_t v);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = v.key;
      if (v.nw) exp_q.push_back('{d: v.dig, o: v.opn, p: v.pos});
      @(negedge clk);
      key_valid = 1'b0;
      chk("key_rejected", key_rejected, v.rej);
      chk("op_clear", op_clear, v.clr);
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) press_vec(tbl[i]);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (calc_start) n_start++;
         if (newNumber) begin
            if (exp_q.size() == 0) chk("newNumber_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("digits", digits, mon_e.d);
               chk("opnumber", opnumber, mon_e.o);
               chk("digitnumber", digitnumber, mon_e.p);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // A: 1 2 3 + 4 5 =
      tbl.push_back(dg(4'd1, 0, 2'd0)); tbl.push_back(dg(4'd2, 0, 2'd1));
      tbl.push_back(dg(4'd3, 0, 2'd2)); tbl.push_back(ky(KEY_ADD, 0, 2'b00));
      tbl.push_back(dg(4'd4, 1, 2'd0)); tbl.push_back(dg(4'd5, 1, 2'd1));
      tbl.push_back(ky(KEY_EQ, 0, 2'b00));
      // B (7..12): CLR, five nines
      tbl.push_back(ky(KEY_CLR, 0, 2'b11));
      tbl.push_back(dg(4'd9, 0, 2'd0)); tbl.push_back(dg(4'd9, 0, 2'd1));
      tbl.push_back(dg(4'd9, 0, 2'd2)); tbl.push_back(dg(4'd9, 0, 2'd3));
      tbl.push_back(ky(4'd9, 1, 2'b00));
      // C (13..17): operator first, EQ in operand 1
      tbl.push_back(ky(KEY_CLR, 0, 2'b11)); tbl.push_back(ky(KEY_ADD, 1, 2'b00));
      tbl.push_back(dg(4'd8, 0, 2'd0)); tbl.push_back(ky(KEY_EQ, 1, 2'b00));
      tbl.push_back(dg(4'd2, 0, 2'd1));
      // D (18..22): timeout run
      tbl.push_back(ky(KEY_CLR, 0, 2'b11)); tbl.push_back(dg(4'd1, 0, 2'd0));
      tbl.push_back(ky(KEY_ADD, 0, 2'b00)); tbl.push_back(dg(4'd2, 1, 2'd0));
      tbl.push_back(ky(KEY_EQ, 0, 2'b00));
      // E (23..24): in error
      tbl.push_back(ky(4'd3, 1, 2'b00)); tbl.push_back(ky(KEY_CLR, 0, 2'b11));
      // F (25..28): done on the timeout cycle
      tbl.push_back(dg(4'd1, 0, 2'd0)); tbl.push_back(ky(KEY_ADD, 0, 2'b00));
      tbl.push_back(dg(4'd2, 1, 2'd0)); tbl.push_back(ky(KEY_EQ, 0, 2'b00));
      // G (29..30): after pending digit
      tbl.push_back(dg(4'd4, 0, 2'd1)); tbl.push_back(ky(KEY_EQ, 1, 2'b00));
      // H (31..35): SUB run, 36: EQ in result
      tbl.push_back(ky(KEY_CLR, 0, 2'b11)); tbl.push_back(dg(4'd1, 0, 2'd0));
      tbl.push_back(ky(KEY_SUB, 0, 2'b00)); tbl.push_back(dg(4'd2, 1, 2'd0));
      tbl.push_back(ky(KEY_EQ, 0, 2'b00)); tbl.push_back(ky(KEY_EQ, 1, 2'b00));
      // I (37..39), J (40)
      tbl.push_back(ky(KEY_CLR, 0, 2'b11)); tbl.push_back(dg(4'd1, 0, 2'd0));
      tbl.push_back(dg(4'd2, 0, 2'd1)); tbl.push_back(dg(4'd3, 0, 2'd0));

      repeat (3) @(negedge clk);
      chk("reset_key_ready", key_ready, 1);
      chk("reset_newNumber", newNumber, 0);
      chk("reset_op_code", op_code, 0);
      chk("reset_result_valid", result_valid, 0);
      chk("reset_err", err, 0);
      chk("reset_calc_start", calc_start, 0);
      chk("reset_load_result", load_result, 0);
      chk("reset_op_clear", op_clear, 0);
      rst = 1'b1;

      run(0, 6);
      chk("a_calc_start", calc_start, 1);
      chk("a_key_ready_wait", key_ready, 0);
      chk("a_op_code", op_code, OP_ADD);
      repeat (2) @(negedge clk);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      chk("a_result_valid", result_valid, 1);
      chk("a_key_ready_result", key_ready, 1);
      chk("a_n_start", n_start, 1);

      run(7, 12);
      chk("b_result_valid_cleared", result_valid, 0);
      run(13, 17);
      chk("c_n_start", n_start, 1);

      run(18, 22);
      wait_cnt = 0;
      while (!err && wait_cnt < 400) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("timeout_cycles", wait_cnt, 255);
      chk("timeout_result_valid", result_valid, 0);
      run(23, 23);
      chk("err_held", err, 1);
      run(24, 24);
      chk("err_cleared", err, 0);

      run(25, 28);
      repeat (254) @(negedge clk);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      chk("edge_result_valid", result_valid, 1);
      chk("edge_err", err, 0);

      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'd7;
      exp_q.push_back('{d: 4'd7, o: 1'b0, p: 2'd0});
      @(negedge clk);
      key_valid = 1'b0;
      chk("pend_op_clear", op_clear, 3);
      chk("pend_key_ready", key_ready, 0);
      chk("pend_newNumber_early", newNumber, 0);
      chk("pend_result_valid", result_valid, 0);
      @(negedge clk);
      chk("pend_key_ready_back", key_ready, 1);
      run(29, 30);

      run(31, 35);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      chk("h_result_valid", result_valid, 1);
      run(36, 36);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = KEY_MUL;
      @(negedge clk);
      key_valid = 1'b0;
`ifdef CALC_CHAIN_EN
      chk("chain_load_result", load_result, 1);
      chk("chain_op_clear", op_clear, 2);
      chk("chain_op_code", op_code, OP_MUL);
      chk("chain_rejected", key_rejected, 0);
      chk("chain_result_valid", result_valid, 0);
      press_vec(dg(4'd6, 1, 2'd0));
`else
      chk("nochain_rejected", key_rejected, 1);
      chk("nochain_load_result", load_result, 0);
      chk("nochain_op_code", op_code, OP_SUB);
      chk("nochain_result_valid", result_valid, 1);
`endif

      run(37, 39);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'd5;
      rst = 1'b0;
      @(negedge clk);
      key_valid = 1'b0;
      chk("rst_newNumber", newNumber, 0);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_op_code", op_code, 0);
      rst = 1'b1;
      run(40, 40);

      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("total_calc_start", n_start, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
